// File: rtl/axi_lite_reg_slave_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite register-bank slave.
package axi_lite_pkg;

    localparam int RESP_OKAY   = 0;
    localparam int RESP_SLVERR = 2;

    localparam int OFF_REG0   = 0;
    localparam int OFF_REG1   = 4;
    localparam int OFF_SUM    = 8;
    localparam int OFF_WCOUNT = 12;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between one master port and the register-bank slave.
// Every channel transfers on a rising edge where valid and ready are both high;
// a source holds valid and payload until that edge, and ready never gates valid.
interface axi_lite_reg_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8:0]   wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [RESP_WIDTH-1:0]   bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [RESP_WIDTH-1:0]   rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_slave_strb_merge.sv
// Byte-strobed merge of new write data over an existing register value.
module axi_strb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_data,
    input  logic [DATA_WIDTH-1:0]   new_data,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   merged
);
    always_comb begin
        merged = old_data;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (strb[i]) merged[i*8 +: 8] = new_data[i*8 +: 8];
        end
    end
endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: two RW operands, their sum and a write-commit counter,
// with independent write and read FSMs and registered channel outputs.
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RESP_WIDTH = 3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [DATA_WIDTH-1:0] REG0_RST   = '0,
    parameter logic [DATA_WIDTH-1:0] REG1_RST   = '0
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_areset,
    axi_lite_reg_slave_if.slave  bus,
    output wr_state_t            dbg_wr_state,
    output rd_state_t            dbg_rd_state
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [RESP_WIDTH-1:0] OKAY   = RESP_WIDTH'(RESP_OKAY);
    localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(RESP_SLVERR);
    localparam logic [ADDR_WIDTH-1:0] A_REG0   = ADDR_WIDTH'(OFF_REG0);
    localparam logic [ADDR_WIDTH-1:0] A_REG1   = ADDR_WIDTH'(OFF_REG1);
    localparam logic [ADDR_WIDTH-1:0] A_SUM    = ADDR_WIDTH'(OFF_SUM);
    localparam logic [ADDR_WIDTH-1:0] A_WCOUNT = ADDR_WIDTH'(OFF_WCOUNT);

    wr_state_t wr_state;
    rd_state_t rd_state;

    logic                  awready, wready, bvalid, arready, rvalid;
    logic [RESP_WIDTH-1:0] bresp, rresp;
    logic [DATA_WIDTH-1:0] rdata;

    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic [DATA_WIDTH-1:0] reg0, reg1, wcount;

    logic aw_hs, w_hs, ar_hs;
    logic                  c_en;
    logic [ADDR_WIDTH-1:0] c_addr, c_off, r_off;
    logic [DATA_WIDTH-1:0] c_data, reg0_next, reg1_next, r_data;
    logic [STRB_W-1:0]     c_strb;
    logic                  c_reg0, c_reg1, c_ok, r_ok;
    logic                  unused_strb;

    assign unused_strb = bus.wstrb[STRB_W];

    assign aw_hs = bus.awvalid & awready;
    assign w_hs  = bus.wvalid & wready;
    assign ar_hs = bus.arvalid & arready;

    // The commit takes address/data from the bus or from whichever half was latched earlier.
    always_comb begin
        c_en   = 1'b0;
        c_addr = aw_addr_q;
        c_data = w_data_q;
        c_strb = w_strb_q;
        case (wr_state)
            WR_IDLE: begin
                c_en   = aw_hs & w_hs;
                c_addr = bus.awaddr;
                c_data = bus.wdata;
                c_strb = bus.wstrb[STRB_W-1:0];
            end
            WR_ADDR: begin
                c_en   = w_hs;
                c_data = bus.wdata;
                c_strb = bus.wstrb[STRB_W-1:0];
            end
            WR_DATA: begin
                c_en   = aw_hs;
                c_addr = bus.awaddr;
            end
            default: ;
        endcase
    end

    assign c_off  = c_addr - BASE_ADDR;
    assign c_reg0 = (c_off == A_REG0);
    assign c_reg1 = (c_off == A_REG1);
    assign c_ok   = c_reg0 | c_reg1;

    axi_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge0 (
        .old_data (reg0),
        .new_data (c_data),
        .strb     (c_strb),
        .merged   (reg0_next)
    );

    axi_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge1 (
        .old_data (reg1),
        .new_data (c_data),
        .strb     (c_strb),
        .merged   (reg1_next)
    );

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            wr_state  <= WR_IDLE;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= '0;
            reg0      <= REG0_RST;
            reg1      <= REG1_RST;
            wcount    <= '0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (c_en) begin
                if (c_reg0) reg0 <= reg0_next;
                if (c_reg1) reg1 <= reg1_next;
                if (c_ok)   wcount <= wcount + 1'b1;
                bresp <= c_ok ? OKAY : SLVERR;
            end
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs && w_hs) begin
                        wr_state <= WR_RESP;
                        awready  <= 1'b0;
                        wready   <= 1'b0;
                        bvalid   <= 1'b1;
                    end else if (aw_hs) begin
                        aw_addr_q <= bus.awaddr;
                        wr_state  <= WR_ADDR;
                        awready   <= 1'b0;
                        wready    <= 1'b1;
                    end else if (w_hs) begin
                        w_data_q <= bus.wdata;
                        w_strb_q <= bus.wstrb[STRB_W-1:0];
                        wr_state <= WR_DATA;
                        awready  <= 1'b1;
                        wready   <= 1'b0;
                    end else begin
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                WR_ADDR: begin
                    if (w_hs) begin
                        wr_state <= WR_RESP;
                        wready   <= 1'b0;
                        bvalid   <= 1'b1;
                    end
                end
                WR_DATA: begin
                    if (aw_hs) begin
                        wr_state <= WR_RESP;
                        awready  <= 1'b0;
                        bvalid   <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (bus.bready) begin
                        wr_state <= WR_IDLE;
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        wready   <= 1'b1;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Reads sample the registers before any same-edge commit lands, so they see old values.
    assign r_off = bus.araddr - BASE_ADDR;
    always_comb begin
        r_data = '0;
        r_ok   = 1'b1;
        case (r_off)
            A_REG0:   r_data = reg0;
            A_REG1:   r_data = reg1;
            A_SUM:    r_data = reg0 + reg1;
            A_WCOUNT: r_data = wcount;
            default:  r_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            rd_state <= RD_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rdata    <= r_data;
                        rresp    <= r_ok ? OKAY : SLVERR;
                        rvalid   <= 1'b1;
                        arready  <= 1'b0;
                        rd_state <= RD_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (bus.rready) begin
                        rvalid   <= 1'b0;
                        arready  <= 1'b1;
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bvalid  = bvalid;
    assign bus.bresp   = bresp;
    assign bus.arready = arready;
    assign bus.rvalid  = rvalid;
    assign bus.rdata   = rdata;
    assign bus.rresp   = rresp;

    assign dbg_wr_state = wr_state;
    assign dbg_rd_state = rd_state;
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: reset checks, W-before-AW, a vector table, stalls,
// simultaneous read/commit and reset during a half-finished write.
module tb_axi_lite_reg_slave;
    import axi_lite_pkg::*;

    localparam logic [31:0] R0_RST = 32'hA5A5_0F0F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    wr_state_t dbg_wr_state;
    rd_state_t dbg_rd_state;

    int checks = 0;
    int errors = 0;

    logic [34:0] b_exp_q[$];
    logic [34:0] r_exp_q[$];

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [4:0]  strb;
        logic [2:0]  resp;
    } vec_t;
    vec_t tbl[18];

    axi_lite_reg_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3)) bus ();

    axi_lite_reg_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3),
        .BASE_ADDR(8'h00), .REG0_RST(R0_RST), .REG1_RST(32'h0)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .bus          (bus),
        .dbg_wr_state (dbg_wr_state),
        .dbg_rd_state (dbg_rd_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_b();
        int n = 0;
        logic [34:0] e;
        while (!bus.bvalid && n < 16) begin
            tick();
            n++;
        end
        e = (b_exp_q.size() > 0) ? b_exp_q.pop_front() : 35'h7_FFFF_FFFF;
        if (!bus.bvalid) check("b_timeout", 64'(bus.bvalid), 64'd1);
        else check("bresp", 64'({bus.bresp, 32'h0}), 64'(e));
        bus.bready = 1'b1;
        tick();
        check("bvalid_clear", 64'(bus.bvalid), 64'd0);
    endtask

    task automatic wait_r();
        int n = 0;
        logic [34:0] e;
        while (!bus.rvalid && n < 16) begin
            tick();
            n++;
        end
        e = (r_exp_q.size() > 0) ? r_exp_q.pop_front() : 35'h7_FFFF_FFFF;
        if (!bus.rvalid) check("r_timeout", 64'(bus.rvalid), 64'd1);
        else check("rresp_rdata", 64'({bus.rresp, bus.rdata}), 64'(e));
        bus.rready = 1'b1;
        tick();
        check("rvalid_clear", 64'(bus.rvalid), 64'd0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                            input logic [2:0] r);
        b_exp_q.push_back({r, 32'h0});
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("wr_latency", 64'(bus.bvalid), 64'd1);
        wait_b();
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] d, input logic [2:0] r);
        r_exp_q.push_back({r, d});
        bus.araddr = a; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        check("rd_latency", 64'(bus.rvalid), 64'd1);
        wait_r();
    endtask

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;

        tbl[0]  = '{1'b1, 8'h00, 32'h1234_5678, 5'h0F, 3'd0};
        tbl[1]  = '{1'b0, 8'h00, 32'h1234_5678, 5'h00, 3'd0};
        tbl[2]  = '{1'b1, 8'h00, 32'hFFFF_FFFF, 5'h0F, 3'd0};
        tbl[3]  = '{1'b1, 8'h04, 32'h0000_0002, 5'h0F, 3'd0};
        tbl[4]  = '{1'b0, 8'h08, 32'h0000_0001, 5'h00, 3'd0};
        tbl[5]  = '{1'b1, 8'h08, 32'hDEAD_BEEF, 5'h0F, 3'd2};
        tbl[6]  = '{1'b0, 8'h30, 32'h0000_0000, 5'h00, 3'd2};
        tbl[7]  = '{1'b1, 8'h02, 32'h0BAD_0BAD, 5'h0F, 3'd2};
        tbl[8]  = '{1'b0, 8'h00, 32'hFFFF_FFFF, 5'h00, 3'd0};
        tbl[9]  = '{1'b0, 8'h04, 32'h0000_0002, 5'h00, 3'd0};
        tbl[10] = '{1'b0, 8'h0C, 32'h0000_0004, 5'h00, 3'd0};
        tbl[11] = '{1'b1, 8'h04, 32'h0000_FFFF, 5'h00, 3'd0};
        tbl[12] = '{1'b0, 8'h04, 32'h0000_0002, 5'h00, 3'd0};
        tbl[13] = '{1'b0, 8'h0C, 32'h0000_0005, 5'h00, 3'd0};
        tbl[14] = '{1'b1, 8'h04, 32'h1122_3344, 5'h12, 3'd0};
        tbl[15] = '{1'b0, 8'h04, 32'h0000_3302, 5'h00, 3'd0};
        tbl[16] = '{1'b0, 8'h0C, 32'h0000_0006, 5'h00, 3'd0};
        tbl[17] = '{1'b0, 8'h08, 32'h0000_3301, 5'h00, 3'd0};

        // Reset state
        tick(); tick();
        check("rst_outputs", 64'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}), 64'd0);
        check("rst_rdata", 64'({bus.rdata, bus.rresp, bus.bresp}), 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 64'({bus.awready, bus.wready, bus.arready}), 64'b111);

        // W three cycles ahead of AW
        bus.wdata = 32'hAABB_CCDD; bus.wstrb = 5'h05; bus.wvalid = 1'b1;
        b_exp_q.push_back({3'd0, 32'h0});
        tick();
        bus.wvalid = 1'b0;
        tick(); tick();
        check("w_first_state", 64'(dbg_wr_state), 64'(WR_DATA));
        check("w_first_ready", 64'({bus.awready, bus.wready, bus.bvalid}), 64'b100);
        bus.awaddr = 8'h04; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("aw_late_latency", 64'(bus.bvalid), 64'd1);
        wait_b();
        do_read(8'h04, 32'h00BB_00DD, 3'd0);
        do_read(8'h0C, 32'h0000_0001, 3'd0);

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].resp);
            else           do_read(tbl[i].addr, tbl[i].data, tbl[i].resp);
        end

        // B channel stalled by bready=0
        bus.bready = 1'b0;
        b_exp_q.push_back({3'd0, 32'h0});
        bus.awaddr = 8'h00; bus.awvalid = 1'b1;
        bus.wdata = 32'h5555_AAAA; bus.wstrb = 5'h0F; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("b_stall", 64'({bus.bvalid, bus.bresp, bus.awready, bus.wready}), 64'b1_000_00);
            tick();
        end
        wait_b();

        // R channel stalled by rready=0
        bus.rready = 1'b0;
        r_exp_q.push_back({3'd0, 32'h5555_AAAA});
        bus.araddr = 8'h00; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("r_stall", 64'({bus.rvalid, bus.rresp, bus.rdata, bus.arready}),
                  64'({1'b1, 3'd0, 32'h5555_AAAA, 1'b0}));
            tick();
        end
        wait_r();

        // Read captured on the commit edge sees the old WCOUNT
        bus.bready = 1'b0;
        b_exp_q.push_back({3'd0, 32'h0});
        r_exp_q.push_back({3'd0, 32'h0000_0007});
        bus.awaddr = 8'h00; bus.awvalid = 1'b1;
        bus.wdata = 32'h0BAD_0000; bus.wstrb = 5'h0F; bus.wvalid = 1'b1;
        bus.araddr = 8'h0C; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        check("simul_valids", 64'({bus.bvalid, bus.rvalid}), 64'b11);
        wait_r();
        wait_b();
        do_read(8'h0C, 32'h0000_0008, 3'd0);
        do_read(8'h00, 32'h0BAD_0000, 3'd0);

        // Reset while waiting for W
        bus.awaddr = 8'h00; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("wr_addr_state", 64'(dbg_wr_state), 64'(WR_ADDR));
        check("wr_addr_ready", 64'({bus.awready, bus.wready}), 64'b01);
        rst = 1'b1;
        tick();
        check("mid_rst_outputs", 64'({bus.bvalid, bus.awready, bus.wready, bus.arready}), 64'd0);
        check("mid_rst_state", 64'(dbg_wr_state), 64'(WR_IDLE));
        rst = 1'b0;
        tick();
        check("mid_rst_ready", 64'({bus.awready, bus.wready, bus.arready}), 64'b111);
        do_read(8'h00, R0_RST, 3'd0);
        do_read(8'h04, 32'h0000_0000, 3'd0);
        do_read(8'h0C, 32'h0000_0000, 3'd0);
        do_write(8'h04, 32'h0000_0010, 5'h0F, 3'd0);
        do_read(8'h08, 32'hA5A5_0F1F, 3'd0);
        do_read(8'h0C, 32'h0000_0001, 3'd0);

        check("queues_empty", 64'(b_exp_q.size() + r_exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
